// File: rtl/mii_pkg.sv
// Shared constants, FSM state type and error-flag layout
// for the 64-bit MII/XGMII receive frame checker.
package mii_pkg;

    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERROR = 8'hFE;

    // Lanes 7..1 of a legal start beat
    localparam logic [55:0] PREAMBLE_SFD = 56'hD5555555555555;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DROP
    } state_t;

    localparam int ERR_PREAMBLE = 0;
    localparam int ERR_FCS      = 1;
    localparam int ERR_RUNT     = 2;
    localparam int ERR_OVERSIZE = 3;
    localparam int ERR_CTRL     = 4;
    localparam int ERR_W        = 5;

    // Lowest lane carrying a control character; 8 when none
    function automatic logic [3:0] first_ctrl_lane(input logic [7:0] ctrl);
        logic [3:0] k;
        k = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (ctrl[i]) k = 4'(i);
        end
        return k;
    endfunction

endpackage

// File: rtl/mii_crc32_d64.sv
// Combinational reflected CRC-32 update over up to eight byte lanes,
// lanes taken in ascending order, each byte LSB first.
module mii_crc32_d64
    import mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [7:0]  byte_en,
    output logic [31:0] crc_out
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (byte_en[l]) begin
                for (int b = 0; b < 8; b++) begin
                    fb = c[0] ^ data[8*l+b];
                    c  = {1'b0, c[31:1]} ^ (fb ? CRC32_POLY : 32'h0);
                end
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_rx_frame_checker.sv
// Receive-side frame delineation, header capture, length and FCS
// checking with good/bad frame counters for a 64-bit MII lane stream.
module mii_rx_frame_checker
    import mii_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_mii_valid_en,
    input  logic [63:0]          i_mii_data,
    input  logic [7:0]           i_mii_ctrl,
    output logic                 o_frame_done,
    output logic                 o_frame_ok,
    output logic [47:0]          o_dest_address,
    output logic [47:0]          o_src_address,
    output logic [15:0]          o_eth_type,
    output logic [15:0]          o_byte_count,
    output logic [ERR_W-1:0]     o_err_flags,
    output logic [CNT_WIDTH-1:0] o_good_cnt,
    output logic [CNT_WIDTH-1:0] o_bad_cnt
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state;
    state_t state_next;

    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic [15:0]      byte_cnt;
    logic [15:0]      cnt_next;
    logic [16:0]      cnt_sum;
    logic [3:0]       lane_k;
    logic [7:0]       byte_en;
    logic [7:0]       term_char;
    logic             is_start;
    logic             pre_ok;
    logic             any_term;
    logic             all_idle;
    logic             in_data;
    logic             start_ok;
    logic             data_end;
    logic             drop_end;
    logic [ERR_W-1:0] end_flags;
    logic [47:0]      da_next;
    logic [47:0]      sa_next;
    logic [15:0]      et_next;
    int               pos;

    mii_crc32_d64 u_crc (
        .crc_in  (crc),
        .data    (i_mii_data),
        .byte_en (byte_en),
        .crc_out (crc_next)
    );

    always_comb begin
        lane_k    = first_ctrl_lane(i_mii_ctrl);
        byte_en   = 8'h00;
        term_char = MII_IDLE;
        any_term  = 1'b0;
        all_idle  = (i_mii_ctrl == 8'hFF);
        for (int i = 0; i < 8; i++) begin
            byte_en[i] = (4'(i) < lane_k);
            if (4'(i) == lane_k) term_char = i_mii_data[8*i+:8];
            if (i_mii_ctrl[i] && i_mii_data[8*i+:8] == MII_TERM) any_term = 1'b1;
            if (i_mii_data[8*i+:8] != MII_IDLE) all_idle = 1'b0;
        end
        is_start = i_mii_ctrl[0] && (i_mii_data[7:0] == MII_START);
        pre_ok   = (i_mii_ctrl[7:1] == 7'h00) && (i_mii_data[63:8] == PREAMBLE_SFD);
        in_data  = i_mii_valid_en && (state == DATA);
    end

    // Byte count saturates rather than wrapping
    always_comb begin
        cnt_sum  = {1'b0, byte_cnt} + 17'(lane_k);
        cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end_flags               = '0;
        end_flags[ERR_CTRL]     = (term_char != MII_TERM);
        end_flags[ERR_OVERSIZE] = (cnt_next > MAX_LEN);
        end_flags[ERR_RUNT]     = (cnt_next < MIN_LEN);
        end_flags[ERR_FCS]      = (crc_next != CRC32_RESIDUE);
    end

    always_comb begin
        da_next = o_dest_address;
        sa_next = o_src_address;
        et_next = o_eth_type;
        pos     = 0;
        if (in_data) begin
            for (int i = 0; i < 8; i++) begin
                pos = int'(byte_cnt) + i;
                if (byte_en[i]) begin
                    if (pos < 6) begin
                        da_next[8*(5-pos)+:8] = i_mii_data[8*i+:8];
                    end else if (pos < 12) begin
                        sa_next[8*(11-pos)+:8] = i_mii_data[8*i+:8];
                    end else if (pos < 14) begin
                        et_next[8*(13-pos)+:8] = i_mii_data[8*i+:8];
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        data_end   = 1'b0;
        drop_end   = 1'b0;
        if (i_mii_valid_en) begin
            unique case (state)
                IDLE: begin
                    if (is_start) begin
                        if (pre_ok) begin
                            state_next = DATA;
                            start_ok   = 1'b1;
                        end else begin
                            state_next = DROP;
                        end
                    end
                end
                DATA: begin
                    if (i_mii_ctrl != 8'h00) begin
                        state_next = IDLE;
                        data_end   = 1'b1;
                    end
                end
                DROP: begin
                    if (any_term || all_idle) begin
                        state_next = IDLE;
                        drop_end   = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            crc            <= CRC32_INIT;
            byte_cnt       <= '0;
            o_frame_done   <= 1'b0;
            o_frame_ok     <= 1'b0;
            o_dest_address <= '0;
            o_src_address  <= '0;
            o_eth_type     <= '0;
            o_byte_count   <= '0;
            o_err_flags    <= '0;
            o_good_cnt     <= '0;
            o_bad_cnt      <= '0;
        end else begin
            o_frame_done   <= 1'b0;
            o_dest_address <= da_next;
            o_src_address  <= sa_next;
            o_eth_type     <= et_next;
            if (start_ok) begin
                crc      <= CRC32_INIT;
                byte_cnt <= '0;
            end else if (in_data) begin
                crc      <= crc_next;
                byte_cnt <= cnt_next;
            end
            if (data_end) begin
                o_frame_done <= 1'b1;
                o_frame_ok   <= (end_flags == '0);
                o_err_flags  <= end_flags;
                o_byte_count <= cnt_next;
                if (end_flags == '0) begin
                    o_good_cnt <= o_good_cnt + CNT_ONE;
                end else begin
                    o_bad_cnt <= o_bad_cnt + CNT_ONE;
                end
            end else if (drop_end) begin
                // Dropped frames carry no byte count
                o_frame_done <= 1'b1;
                o_frame_ok   <= 1'b0;
                o_err_flags  <= ERR_W'(1) << ERR_PREAMBLE;
                o_byte_count <= '0;
                o_bad_cnt    <= o_bad_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mii_rx_frame_checker.sv
// Scoreboard bench for mii_rx_frame_checker: byte-level frame model
// feeds expected results; a monitor checks each done pulse.
module tb_mii_rx_frame_checker;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam logic [63:0] IDLE_BEAT = {8{8'h07}};
    localparam logic [63:0] START_BEAT = {56'hD5555555555555, 8'hFB};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        done;
    logic        ok;
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] et;
    logic [15:0] bc;
    logic [4:0]  flags;
    logic [31:0] good;
    logic [31:0] bad;

    always #5 clk = ~clk;

    mii_rx_frame_checker #(
        .MIN_FRAME_LEN (MIN_LEN),
        .MAX_FRAME_LEN (MAX_LEN),
        .CNT_WIDTH     (32)
    ) dut (
        .clk            (clk),
        .i_rst_n        (rst_n),
        .i_mii_valid_en (valid),
        .i_mii_data     (data),
        .i_mii_ctrl     (ctrl),
        .o_frame_done   (done),
        .o_frame_ok     (ok),
        .o_dest_address (da),
        .o_src_address  (sa),
        .o_eth_type     (et),
        .o_byte_count   (bc),
        .o_err_flags    (flags),
        .o_good_cnt     (good),
        .o_bad_cnt      (bad)
    );

    typedef struct {
        logic        ok;
        logic [4:0]  flags;
        logic [15:0] bc;
        bit          chk_bc;
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] et;
        int unsigned good;
        int unsigned bad;
        longint      cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  fr[$];
    int          passed = 0;
    int          total = 0;
    longint      cyc = 0;
    int          gap_at = -1;
    logic [47:0] m_da = '0;
    logic [47:0] m_sa = '0;
    logic [15:0] m_et = '0;
    int unsigned m_good = 0;
    int unsigned m_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done !== 1'b0) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: done=%b with no frame pending", done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", cyc, e.cyc);
                chk("frame_ok", ok, e.ok);
                chk("err_flags", flags, e.flags);
                if (e.chk_bc) chk("byte_count", bc, e.bc);
                chk("dest_addr", da, e.da);
                chk("src_addr", sa, e.sa);
                chk("eth_type", et, e.et);
                chk("good_cnt", good, e.good);
                chk("bad_cnt", bad, e.bad);
            end
        end
    end

    // Standard byte-at-a-time reflected CRC-32
    function automatic logic [31:0] crc_bytes(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [63:0] beat_of(input int i);
        logic [63:0] d;
        for (int l = 0; l < 8; l++) d[8*l+:8] = (i + l < fr.size()) ? fr[i+l] : 8'h00;
        return d;
    endfunction

    task automatic build_frame(input logic [47:0] f_da, input logic [47:0] f_sa,
                               input logic [15:0] f_et, input int plen, input int fill);
        logic [31:0] c;
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(f_da[8*(5-i)+:8]);
        for (int i = 0; i < 6; i++) fr.push_back(f_sa[8*(5-i)+:8]);
        fr.push_back(f_et[15:8]);
        fr.push_back(f_et[7:0]);
        for (int i = 0; i < plen; i++) fr.push_back(fill < 0 ? 8'($urandom) : 8'(fill));
        c = ~crc_bytes(fr.size());
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i+:8]);
    endtask

    task automatic expect_frame(input bit bad_pre, input bit term_e, output exp_t e);
        int          n;
        logic [31:0] tail;
        logic        fcs_ok;
        n = fr.size();
        e.chk_bc = !bad_pre;
        if (bad_pre) begin
            e.flags = 5'b00001;
            e.bc = '0;
        end else begin
            fcs_ok = 1'b0;
            if (n >= 4) begin
                tail = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
                fcs_ok = (tail == ~crc_bytes(n - 4));
            end
            e.flags = {term_e, n > MAX_LEN, n < MIN_LEN, !fcs_ok, 1'b0};
            e.bc = (n > 65535) ? 16'hFFFF : 16'(n);
            for (int i = 0; i < n && i < 14; i++) begin
                if (i < 6) m_da[8*(5-i)+:8] = fr[i];
                else if (i < 12) m_sa[8*(11-i)+:8] = fr[i];
                else m_et[8*(13-i)+:8] = fr[i];
            end
        end
        e.ok = (e.flags == 5'b0);
        if (e.ok) m_good++;
        else m_bad++;
        e.da = m_da;
        e.sa = m_sa;
        e.et = m_et;
        e.good = m_good;
        e.bad = m_bad;
        e.cyc = 0;
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        @(negedge clk);
        valid = 1'b1;
        data = d;
        ctrl = c;
    endtask

    task automatic gap(input int g);
        repeat (g) begin
            @(negedge clk);
            valid = 1'b0;
            data = {$urandom, $urandom};
            ctrl = 8'($urandom);
        end
    endtask

    task automatic idle_beats(input int n);
        repeat (n) drive(IDLE_BEAT, 8'hFF);
    endtask

    // term: 0 = /T/, 1 = /E/, 2 = all-idle beat (dropped frames only)
    task automatic send_frame(input bit bad_pre, input int term);
        int          n;
        int          i;
        int          b;
        int          r;
        logic [63:0] d;
        logic [7:0]  c;
        exp_t        e;
        n = fr.size();
        i = 0;
        b = 0;
        d = START_BEAT;
        if (bad_pre) d[63:56] = 8'h55;
        drive(d, 8'h01);
        while ((n - i >= 8) || (bad_pre && i < n)) begin
            if (b == gap_at) gap(5);
            drive(beat_of(i), 8'h00);
            i += 8;
            b++;
        end
        if (b == gap_at) gap(5);
        d = IDLE_BEAT;
        c = 8'hFF;
        r = (n > i) ? n - i : 0;
        for (int l = 0; l < r; l++) begin
            d[8*l+:8] = fr[i+l];
            c[l] = 1'b0;
        end
        if (term != 2) d[8*r+:8] = (term == 1) ? 8'hFE : 8'hFD;
        expect_frame(bad_pre, term == 1, e);
        @(negedge clk);
        valid = 1'b1;
        data = d;
        ctrl = c;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r1;
        logic [63:0] r2;
        int          plen;
        int          sel;
        int          term;
        int          keep;
        bit          bp;

        rst_n = 1'b0;
        valid = 1'b0;
        data = '0;
        ctrl = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_done", done, 1'b0);
        chk("rst_ok", ok, 1'b0);
        chk("rst_flags", flags, 5'b0);
        chk("rst_bc", bc, 16'h0);
        chk("rst_da", da, 48'h0);
        chk("rst_sa", sa, 48'h0);
        chk("rst_et", et, 16'h0);
        chk("rst_good", good, 32'h0);
        chk("rst_bad", bad, 32'h0);

        idle_beats(2);
        build_frame(48'hFFFFFFFFFFFF, 48'h123456789ABC, 16'h0800, 46, 8'hAA);
        send_frame(1'b0, 0);
        idle_beats(2);

        fr[63] ^= 8'h01;
        send_frame(1'b0, 0);
        idle_beats(2);

        build_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h86DD, 8, -1);
        send_frame(1'b0, 0);
        idle_beats(2);

        build_frame(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h1234, 6, -1);
        send_frame(1'b1, 0);
        idle_beats(1);
        send_frame(1'b1, 2);
        idle_beats(1);

        build_frame(48'h665544332211, 48'h0123456789AB, 16'h0806, 82, -1);
        send_frame(1'b0, 1);
        build_frame(48'h020406080A0C, 48'h10305070900B, 16'h0800, 50, -1);
        send_frame(1'b0, 0);
        idle_beats(3);

        build_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 46, -1);
        drive(START_BEAT, 8'h01);
        drive(beat_of(0), 8'h00);
        drive(beat_of(8), 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b1;
        data = beat_of(16);
        ctrl = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        m_da = '0;
        m_sa = '0;
        m_et = '0;
        m_good = 0;
        m_bad = 0;
        @(negedge clk);
        chk("midrst_good", good, 32'h0);
        chk("midrst_bad", bad, 32'h0);
        chk("midrst_da", da, 48'h0);
        chk("midrst_done", done, 1'b0);
        send_frame(1'b0, 0);
        idle_beats(2);

        build_frame(48'h00AABBCCDDEE, 48'h00FFEEDDCCBB, 16'h88B5, 82, 8'h3C);
        send_frame(1'b0, 0);
        idle_beats(1);
        gap_at = 3;
        send_frame(1'b0, 0);
        gap_at = -1;
        idle_beats(2);

        build_frame(48'h0000000000AA, 48'h0000000000BB, 16'h0800, 1502, -1);
        send_frame(1'b0, 0);
        build_frame(48'h0000000000CC, 48'h0000000000DD, 16'h0800, 1500, -1);
        send_frame(1'b0, 0);
        idle_beats(1);

        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 9);
            bp = (sel == 0);
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            plen = (sel == 1) ? $urandom_range(1480, 1510) : $urandom_range(0, 100);
            build_frame(r1[47:0], r2[47:0], r2[63:48], plen, -1);
            if (sel == 2 || sel == 3) fr[$urandom_range(0, fr.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
            term = 0;
            if (sel == 4) begin
                term = 1;
                keep = $urandom_range(1, fr.size());
                while (fr.size() > keep) void'(fr.pop_back());
            end
            if (bp) term = ($urandom_range(0, 1) == 1) ? 2 : 0;
            gap_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
            send_frame(bp, term);
            gap_at = -1;
            idle_beats($urandom_range(0, 2));
        end

        idle_beats(2);
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        chk("scoreboard_drain", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mii_rx_frame_checker.md
Name: mii_rx_frame_checker

Overview:
- Downstream consumer of the MAC→MII generator's 64-bit XGMII-style lane stream (8 data bytes plus 8 per-lane control flags per clock).
- Delineates frames and captures the Ethernet header.
- Counts frame bytes, checks length limits and the FCS residue, and keeps good/bad frame counters.
- Serves as the scoreboard-side checker in MII/BASE-R verification and as a reusable RX-side frame parser.

Parameters:
- MIN_FRAME_LEN, 64, minimum legal frame length in bytes (DA through FCS); shorter frames flag runt.
- MAX_FRAME_LEN, 1518, maximum legal frame length in bytes; longer frames flag oversize.
- CNT_WIDTH, 32, width of the good and bad frame counters.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_mii_valid_en  in  1  beat qualifier; when low the beat is ignored and all state is held.
- i_mii_data  in  64  lane k = bits [8k+7:8k]; lane 0 is transmitted first.
- i_mii_ctrl  in  8  bit k=1 marks lane k as a control character.
- o_frame_done  out  1  one-cycle pulse per frame delineated by /T/ or error.
- o_frame_ok  out  1  valid with o_frame_done; 1 = no error flags.
- o_dest_address  out  48  DA; first byte received goes to [47:40].
- o_src_address  out  48  SA; first byte goes to [47:40].
- o_eth_type  out  16  EtherType, big-endian.
- o_byte_count  out  16  data bytes from DA through FCS; saturates at 16'hFFFF.
- o_err_flags  out  5  {ctrl, oversize, runt, fcs, preamble}; valid with o_frame_done.
- o_good_cnt  out  CNT_WIDTH  frames with o_frame_ok=1; wraps.
- o_bad_cnt  out  CNT_WIDTH  frames with o_frame_ok=0; wraps.

Behaviour:
- Control characters:
  - /I/ = 0x07, /S/ = 0xFB, /T/ = 0xFD, /E/ = 0xFE.
  - Start is legal only in lane 0.
- Reset:
  - FSM returns to IDLE.
  - All outputs are 0, CRC register is 32'hFFFFFFFF, byte counter is 0.
  - Reset mid-frame discards the frame: no done pulse and no counter update.
- IDLE state:
  - Entry to DATA requires lane 0 = /S/ (ctrl=1), lanes 1-6 = 0x55 and lane 7 = 0xD5, all with ctrl=0.
  - /S/ with a bad preamble/SFD: enter DROP and latch the preamble error.
  - /S/ in lanes 1-7: ignored; stay in IDLE.
- DATA state:
  - A beat with ctrl=0 on all lanes carries 8 data bytes.
  - Let k be the lowest lane with ctrl=1.
  - If lane k = /T/: lanes 0..k-1 are data, the frame ends, and the FSM returns to IDLE.
  - If lane k is any other control character: latch ctrl error, count bytes 0..k-1, end the frame, return to IDLE.
  - /T/ in lane 0 contributes 0 bytes.
- DROP state:
  - Wait for any /T/, or for an all-/I/ beat.
  - Then pulse o_frame_done with o_frame_ok=0 and return to IDLE.
- Header capture:
  - Frame bytes 0-5 form DA, 6-11 SA, 12-13 EtherType.
  - Header fields update as bytes arrive and hold until the next frame's bytes overwrite them.
  - If a frame ends before byte 13, uncaptured fields keep their previous values.
- FCS check:
  - Reflected CRC-32 (poly 0xEDB88320), init 32'hFFFFFFFF, no final XOR.
  - Bytes are processed LSB-first in lane order across all frame data bytes, including the FCS.
  - The frame is good when the final register equals 32'hDEBB20E3; otherwise latch fcs error.
  - CRC and byte count re-initialise on every accepted /S/.
- Length checks, evaluated at frame end:
  - runt if count < MIN_FRAME_LEN.
  - oversize if count > MAX_FRAME_LEN.
- Output timing:
  - o_frame_done asserts on the clock edge after the terminating beat is sampled (latency 1).
  - o_err_flags, o_byte_count and o_frame_ok are registered with the done pulse.
  - Counters update in the same cycle as o_frame_done.
- Back-to-back frames: a valid /S/ beat directly after the /T/ beat is accepted. Its done pulse for the previous frame and its new-frame start coexist.
- i_mii_valid_en low: the beat is not sampled. A pending done pulse still fires exactly once.

Decomposition:
- Package mii_pkg holds:
  - Control-character constants (MII_IDLE/START/TERM/ERROR).
  - PREAMBLE_SFD = 56'hD5555555555555 (lanes 7..1).
  - CRC32_POLY and CRC32_RESIDUE.
  - The FSM state enum {IDLE, DATA, DROP}.
  - The err-flag bit indices.
- One sub-module: mii_crc32_d64, a combinational next-CRC calculation.
  - Inputs: 32-bit CRC, 64-bit data, 8-bit byte-enable mask.
  - Processes enabled lanes in ascending order.
  - The top module registers the result.

Test Plan:
- Good min frame: /S/+preamble, DA FFFFFFFFFFFF, SA 123456789ABC, type 0800, 46 bytes of 0xAA plus correct FCS (8 full beats), then /T/ in lane 0 → done 1 cycle after /T/, ok=1, byte_count=64, flags=0, good_cnt=1, header outputs match.
- Same frame with FCS byte 63 XOR 0x01 → ok=0, flags=5'b00010, bad_cnt=1, byte_count=64.
- Frame with 8-byte payload, no padding (26 bytes, /T/ in lane 2 of the 4th beat) → byte_count=26, runt set, fcs clear when the FCS is correct.
- /S/ with lane 7 = 0x55 (bad SFD), then 3 beats of data, then /T/ → one done pulse, flags=5'b00001, bad_cnt=1, header outputs unchanged.
- /E/ in lane 4 mid-payload → frame ends, ctrl flag set; a valid /S/ on the very next beat produces a second frame that checks ok=1.
- i_rst_n low for 1 cycle during beat 3 of a frame → no done pulse, counters 0. A following good frame reports ok=1. With i_mii_valid_en held low for 5 cycles mid-frame, the result is identical to the gap-free run.
